// File: rtl/vx_om_tile_responder.sv
// OM tile responder: word-granular read/byte-write slave over a local SRAM.
// Optional tile clear engine enabled by VX_OM_TILE_CLEAR_EN.
module vx_om_tile_responder #(
  parameter int DEPTH          = 1024,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAG_WIDTH      = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int READ_LATENCY   = 2,
  parameter int RSP_QUEUE_SIZE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_byteen,
  input  logic [31:0]           req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready,
  output logic                  write_notify,
  output logic                  addr_err,
  input  logic                  clear_start,
  input  logic [31:0]           clear_value,
  output logic                  clear_busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int QW = (RSP_QUEUE_SIZE > 1) ? $clog2(RSP_QUEUE_SIZE) : 1;
  localparam int CW = $clog2(RSP_QUEUE_SIZE + 1);
  localparam logic [CW-1:0] QFULL = CW'(RSP_QUEUE_SIZE);

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic [IW-1:0]         widx;
  logic                  in_range;
  logic                  fire, rd_fire, wr_fire;
  logic [31:0]           rd_word;
  logic                  ready_q;
  logic [CW-1:0]         credits;
  logic                  push, pop;
  logic [31:0]           push_data;
  logic [TAG_WIDTH-1:0]  push_tag;
  logic                  clr_we;
  logic [IW-1:0]         clr_idx;
  logic [31:0]           clr_val;
  logic                  busy;

  assign idx      = req_addr - BASE_ADDR;
  assign in_range = idx < ADDR_WIDTH'(DEPTH);
  assign widx     = idx[IW-1:0];
  assign req_ready = ready_q & ~busy & (credits != '0);
  assign fire     = req_valid & req_ready;
  assign rd_fire  = fire & ~req_rw;
  assign wr_fire  = fire & req_rw;
  assign rd_word  = in_range ? mem[widx] : '0;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= clr_val;
    end else if (wr_fire & in_range) begin
      for (int b = 0; b < 4; b++)
        if (req_byteen[b]) mem[widx][8*b +: 8] <= req_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q      <= 1'b0;
      credits      <= QFULL;
      write_notify <= 1'b0;
      addr_err     <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      credits      <= credits - CW'(rd_fire) + CW'(pop);
      write_notify <= wr_fire;
      addr_err     <= addr_err | (fire & ~in_range);
    end
  end

  // The response queue itself is the final latency stage.
  if (READ_LATENCY > 1) begin : g_pipe
    logic [READ_LATENCY-2:0] pv;
    logic [31:0]             pd [READ_LATENCY-1];
    logic [TAG_WIDTH-1:0]    pt [READ_LATENCY-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pv <= '0;
      end else begin
        pv[0] <= rd_fire;
        for (int k = 1; k < READ_LATENCY-1; k++)
          pv[k] <= pv[k-1];
      end
    end

    always_ff @(posedge clk) begin
      pd[0] <= rd_word;
      pt[0] <= req_tag;
      for (int k = 1; k < READ_LATENCY-1; k++) begin
        pd[k] <= pd[k-1];
        pt[k] <= pt[k-1];
      end
    end

    assign push      = pv[READ_LATENCY-2];
    assign push_data = pd[READ_LATENCY-2];
    assign push_tag  = pt[READ_LATENCY-2];
  end else begin : g_nopipe
    assign push      = rd_fire;
    assign push_data = rd_word;
    assign push_tag  = req_tag;
  end

  logic [31:0]          qd [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0] qt [RSP_QUEUE_SIZE];
  logic [QW-1:0]        wp, rp;
  logic [CW-1:0]        cnt;

  function automatic logic [QW-1:0] inc(input logic [QW-1:0] p);
    return (p == QW'(RSP_QUEUE_SIZE-1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_valid = cnt != '0;
  assign rsp_data  = qd[rp];
  assign rsp_tag   = qt[rp];
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop)  rp <= inc(rp);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      qd[wp] <= push_data;
      qt[wp] <= push_tag;
    end
  end

`ifdef VX_OM_TILE_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t    state, nstate;
  logic          pend, take;
  logic [IW-1:0] ccnt;
  logic [31:0]   cval;

  // A start seen while reads are outstanding waits here until drained.
  assign take = (state == IDLE) & (clear_start | pend) & (credits == QFULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (take) nstate = CLEAR;
      CLEAR:   if (ccnt == IW'(DEPTH-1)) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    busy   = state == CLEAR;
    clr_we = state == CLEAR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0;
      ccnt <= '0;
      cval <= '0;
    end else begin
      if (take) begin
        pend <= 1'b0;
        ccnt <= '0;
        cval <= clear_value;
      end else begin
        if (state == IDLE && clear_start) pend <= 1'b1;
        if (state == CLEAR) ccnt <= ccnt + 1'b1;
      end
    end
  end

  assign clr_idx = ccnt;
  assign clr_val = cval;
`else
  logic unused_clr;
  assign unused_clr = ^{clear_start, clear_value};
  assign busy    = 1'b0;
  assign clr_we  = 1'b0;
  assign clr_idx = '0;
  assign clr_val = '0;
`endif

  assign clear_busy = busy;

endmodule
